// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: picks the next PC, runs the imem req/ready
// handshake and holds one redirect that arrives while a fetch is outstanding.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_in,
  output logic        pc_stall,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        if_valid,
  output logic        if_flush
);

  typedef enum logic [0:0] {StBoot, StFetch} state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        fetch;
  logic        done;
  logic        redir;
  logic [31:0] redir_addr;

  assign fetch = (state_q == StFetch);
  assign done  = fetch & imem_ready;
  // Redirects only count once fetching; in BOOT they are ignored.
  assign redir = fetch & (exc_valid | br_taken | jmp_valid);

  // Highest-priority direct redirect target.
  always_comb begin
    redir_addr = jmp_target;
    if (exc_valid) begin
      redir_addr = EXC_VEC;
    end else if (br_taken) begin
      redir_addr = br_target;
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StBoot;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Next state: BOOT lasts exactly one cycle, FETCH is left only by reset.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StBoot;
    endcase
  end

  // Pending redirect: captured while the fetch is outstanding (latest wins),
  // consumed by any completed fetch.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (done) begin
      pend_valid_d = 1'b0;
    end else if (redir) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = redir_addr;
    end
  end

  assign imem_addr = pc_out;

  // Outputs decoded from state, pending entry and current inputs.
  always_comb begin
    imem_req = 1'b0;
    pc_in    = RESET_VEC;
    pc_stall = 1'b1;
    if_valid = 1'b0;
    if_flush = 1'b0;
    if (fetch) begin
      imem_req = 1'b1;
      if_flush = redir;
      if (!done) begin
        pc_in = pc_out;
      end else if (redir) begin
        pc_in = redir_addr;
      end else if (pend_valid_q) begin
        pc_in = pend_addr_q;
      end else begin
        pc_in = pc_out + 32'd4;
      end
      // A load-use stall holds the PC only when nothing redirects it.
      pc_stall = !(done & (redir | pend_valid_q | !hazard_stall));
      if_valid = done & !redir & !pend_valid_q & !hazard_stall;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a falling-edge PC register model and a
// queue-based scoreboard checked by an independent monitor.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        hazard_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        exc_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        if_valid;
  logic        if_flush;

  logic        pc_load;
  logic [31:0] pc_load_val;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pin;
    logic        stall;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc_out       (pc_out),
    .pc_in        (pc_in),
    .pc_stall     (pc_stall),
    .hazard_stall (hazard_stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .exc_valid    (exc_valid),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .if_valid     (if_valid),
    .if_flush     (if_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register: samples pc_in/pc_stall on the falling edge.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc_out <= 32'h0;
    end else if (pc_load) begin
      pc_out <= pc_load_val;
    end else if (!pc_stall) begin
      pc_out <= pc_in;
    end
  end

  // One vector = one cycle: drive just after the rising edge, queue expectation.
  task automatic vec(input string nm, input logic rst, input logic rdy, input logic hz,
                     input logic exc, input logic br, input logic [31:0] bt,
                     input logic jv, input logic [31:0] jt,
                     input logic req, input logic [31:0] addr, input logic [31:0] pin,
                     input logic stall, input logic valid, input logic flush);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    imem_ready   = rdy;
    hazard_stall = hz;
    exc_valid    = exc;
    br_taken     = br;
    br_target    = bt;
    jmp_valid    = jv;
    jmp_target   = jt;
    e.name  = nm;
    e.req   = req;
    e.addr  = addr;
    e.pin   = pin;
    e.stall = stall;
    e.valid = valid;
    e.flush = flush;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] expv);
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s.%s: got %h, expected %h", nm, field, act, expv);
    end
  endtask

  // Monitor: mid-window sample, pop and compare every presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk(e.name, "imem_req", {31'h0, imem_req}, {31'h0, e.req});
        chk(e.name, "imem_addr", imem_addr, e.addr);
        chk(e.name, "pc_in", pc_in, e.pin);
        chk(e.name, "pc_stall", {31'h0, pc_stall}, {31'h0, e.stall});
        chk(e.name, "if_valid", {31'h0, if_valid}, {31'h0, e.valid});
        chk(e.name, "if_flush", {31'h0, if_flush}, {31'h0, e.flush});
      end
    end
  end

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b0;
    imem_ready   = 1'b1;
    hazard_stall = 1'b0;
    exc_valid    = 1'b0;
    br_taken     = 1'b0;
    br_target    = 32'h0;
    jmp_valid    = 1'b0;
    jmp_target   = 32'h0;
    pc_load      = 1'b0;
    pc_load_val  = 32'h0;
    repeat (3) @(posedge clk);

    //   name          rst rdy hz exc br bt         jv jt         req addr         pc_in        stl val fl
    vec("boot",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     0, 32'h0,       32'h0,       1, 0, 0);
    vec("seq0",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h0,       32'h4,       0, 1, 0);
    vec("seq4",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h4,       32'h8,       0, 1, 0);
    vec("seq8",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h8,       32'hC,       0, 1, 0);
    vec("seqC",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'hC,       32'h10,      0, 1, 0);
    vec("wait1",       1, 0, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h10,      32'h10,      1, 0, 0);
    vec("wait2",       1, 0, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h10,      32'h10,      1, 0, 0);
    vec("wait3",       1, 0, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h10,      32'h10,      1, 0, 0);
    vec("wait_done",   1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h10,      32'h14,      0, 1, 0);
    vec("seq14",       1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h14,      32'h18,      0, 1, 0);
    vec("br_wait",     1, 0, 0, 0, 1, 32'h40,     0, 32'h0,     1, 32'h18,      32'h18,      1, 0, 1);
    vec("pend_wait",   1, 0, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h18,      32'h18,      1, 0, 0);
    vec("pend_use",    1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h18,      32'h40,      0, 0, 0);
    vec("pend_clr",    1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h40,      32'h44,      0, 1, 0);
    vec("late_br",     1, 0, 0, 0, 1, 32'h100,    0, 32'h0,     1, 32'h44,      32'h44,      1, 0, 1);
    vec("late_jmp",    1, 0, 0, 0, 0, 32'h0,      1, 32'h200,   1, 32'h44,      32'h44,      1, 0, 1);
    vec("late_use",    1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h44,      32'h200,     0, 0, 0);
    vec("prio_exc",    1, 1, 0, 1, 1, 32'h40,     1, 32'h80,    1, 32'h200,     32'h180,     0, 0, 1);
    vec("prio_br",     1, 1, 0, 0, 1, 32'h40,     1, 32'h80,    1, 32'h180,     32'h40,      0, 0, 1);
    vec("jmp",         1, 1, 0, 0, 0, 32'h0,      1, 32'h1C,    1, 32'h40,      32'h1C,      0, 0, 1);
    vec("seq1C",       1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h1C,      32'h20,      0, 1, 0);
    vec("hz_hold",     1, 1, 1, 0, 0, 32'h0,      0, 32'h0,     1, 32'h20,      32'h24,      1, 0, 0);
    vec("hz_br",       1, 1, 1, 0, 1, 32'h60,     0, 32'h0,     1, 32'h20,      32'h60,      0, 0, 1);
    vec("seq60",       1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h60,      32'h64,      0, 1, 0);
    vec("exc_wait",    1, 0, 0, 1, 0, 32'h0,      0, 32'h0,     1, 32'h64,      32'h64,      1, 0, 1);
    vec("hz_pend",     1, 1, 1, 0, 0, 32'h0,      0, 32'h0,     1, 32'h64,      32'h180,     0, 0, 0);
    vec("seq180",      1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h180,     32'h184,     0, 1, 0);
    pc_load_val = 32'hFFFF_FFFC;
    pc_load     = 1'b1;
    vec("wrap",        1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'hFFFF_FFFC, 32'h0,     0, 1, 0);
    pc_load     = 1'b0;
    vec("seq0b",       1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h0,       32'h4,       0, 1, 0);
    vec("br_pend",     1, 0, 0, 0, 1, 32'h300,    0, 32'h0,     1, 32'h4,       32'h4,       1, 0, 1);
    vec("rst_mid",     0, 0, 0, 1, 0, 32'h0,      0, 32'h0,     0, 32'h0,       32'h0,       1, 0, 0);
    vec("boot_ign",    1, 1, 0, 1, 1, 32'h500,    0, 32'h0,     0, 32'h0,       32'h0,       1, 0, 0);
    vec("post_rst",    1, 1, 0, 0, 0, 32'h0,      0, 32'h0,     1, 32'h0,       32'h4,       0, 1, 0);

    repeat (3) @(posedge clk);
    #4;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
